// File: rtl/bp_stream_pump_in.sv
`default_nettype none
// ============================================================================
// Module   : bp_stream_pump_in
// Brief    : Converts an inbound memory stream into per-beat FSM transactions,
//            expanding data-less streamed headers into addressed beats.
// Revision : 1.0 - initial release
// ============================================================================
module bp_stream_pump_in #(
    // 0 selects the default processor configuration (40-bit physical address)
    parameter int          bp_params_p         = 0,
    parameter int          stream_data_width_p = 64,
    parameter int          block_width_p       = 512,
    parameter logic [15:0] payload_mask_p      = '0,
    parameter logic [15:0] stream_mask_p       = '0,
    localparam int C_PADDR_W = (bp_params_p == 0) ? 40 : 56,
    localparam int C_HDR_W   = C_PADDR_W + 15,
    localparam int C_WORDS   = block_width_p / stream_data_width_p,
    localparam int C_CNT_W   = (C_WORDS > 1) ? $clog2(C_WORDS) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [C_HDR_W-1:0]             mem_header_i,
    input  logic [stream_data_width_p-1:0] mem_data_i,
    input  logic                           mem_v_i,
    input  logic                           mem_last_i,
    output logic                           mem_ready_and_o,
    output logic [C_HDR_W-1:0]             fsm_base_header_o,
    output logic [C_PADDR_W-1:0]           fsm_addr_o,
    output logic [stream_data_width_p-1:0] fsm_data_o,
    output logic                           fsm_v_o,
    input  logic                           fsm_ready_and_i,
    output logic [C_CNT_W-1:0]             stream_cnt_o,
    output logic                           stream_new_o,
    output logic                           stream_done_o
);

    localparam int C_OFF_W   = $clog2(stream_data_width_p / 8);
    localparam int C_MAX_LOG = $clog2(C_WORDS);

    typedef enum logic [0:0] {
        ST_READY  = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_streaming;
    logic [C_HDR_W-1:0]   r_header;
    logic [C_CNT_W-1:0]   r_cnt;

    logic [C_HDR_W-1:0]   w_header;
    logic [3:0]           w_type;
    logic [2:0]           w_size;
    logic [C_PADDR_W-1:0] w_addr;
    logic [C_CNT_W-1:0]   w_mask;
    logic [C_CNT_W-1:0]   w_first_cnt;
    logic [C_CNT_W-1:0]   w_last_cnt;
    logic [C_CNT_W-1:0]   w_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_streamed;
    logic                 w_expand;
    logic                 w_last_beat;
    logic                 w_accept;

    // Mid-message the decode comes from the captured header, so the bus side
    // may change (or be unacknowledged) without disturbing the beat sequence.
    assign w_header = r_streaming ? r_header : mem_header_i;
    assign w_type   = w_header[3:0];
    assign w_size   = w_header[6:4];
    assign w_addr   = w_header[7 +: C_PADDR_W];

    // Beat-window mask: log2(num_stream) low ones, clamped to the block
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < C_CNT_W; i++) begin
            if ((i < C_MAX_LOG) && (int'(w_size) > (i + C_OFF_W))) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign w_first_cnt = w_addr[C_OFF_W +: C_CNT_W];
    assign w_last_cnt  = (w_first_cnt & ~w_mask) | ((w_first_cnt + w_mask) & w_mask);
    assign w_streamed  = stream_mask_p[w_type] & w_mask[0];
    assign w_expand    = w_streamed & ~payload_mask_p[w_type];

    assign w_cnt       = (r_state == ST_STREAM) ? r_cnt : w_first_cnt;
    assign w_last_beat = ~w_streamed | (w_cnt == w_last_cnt);
    assign w_cnt_nxt   = (w_cnt & ~w_mask) | ((w_cnt + C_CNT_W'(1)) & w_mask);

    assign fsm_v_o         = mem_v_i & ~reset_i;
    assign w_accept        = fsm_v_o & fsm_ready_and_i;
    assign mem_ready_and_o = ~reset_i & fsm_ready_and_i & (~w_expand | w_last_beat);
    assign stream_new_o    = w_accept & (r_state == ST_READY);
    assign stream_done_o   = w_accept & w_last_beat;

    assign fsm_base_header_o = w_header;
    assign fsm_data_o        = mem_data_i;
    assign stream_cnt_o      = w_cnt;

    // Beat bits wrap inside the size-aligned window; all other bits pass through
    always_comb begin
        fsm_addr_o = w_addr;
        fsm_addr_o[C_OFF_W +: C_CNT_W] = (w_first_cnt & ~w_mask) | (w_cnt & w_mask);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_READY:  if (w_accept && !w_last_beat) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_accept &&  w_last_beat) w_state_nxt = ST_READY;
            default:   w_state_nxt = ST_READY;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_READY;
            r_streaming <= 1'b0;
            r_header    <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_streaming <= (w_state_nxt == ST_STREAM);
            if (stream_new_o) begin
                r_header <= mem_header_i;
            end
            if (w_accept && !w_last_beat) begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    // The sender's last flag must agree with our own beat count
    always_ff @(posedge clk_i) begin
        if (!reset_i && w_accept && !w_expand) begin
            assert (mem_last_i == stream_done_o);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_stream_pump_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_stream_pump_in
// Brief    : Scoreboard bench for bp_stream_pump_in (W=64, block=512).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_stream_pump_in;

    localparam int C_HDR_W = 55;

    logic                clk_i = 1'b0;
    logic                reset_i = 1'b1;
    logic [C_HDR_W-1:0]  mem_header_i = '0;
    logic [63:0]         mem_data_i = '0;
    logic                mem_v_i = 1'b0;
    logic                mem_last_i = 1'b0;
    logic                mem_ready_and_o;
    logic [C_HDR_W-1:0]  fsm_base_header_o;
    logic [39:0]         fsm_addr_o;
    logic [63:0]         fsm_data_o;
    logic                fsm_v_o;
    logic                fsm_ready_and_i = 1'b1;
    logic [2:0]          stream_cnt_o;
    logic                stream_new_o;
    logic                stream_done_o;

    bp_stream_pump_in #(
        .bp_params_p         (0),
        .stream_data_width_p (64),
        .block_width_p       (512),
        .payload_mask_p      (16'h0002),
        .stream_mask_p       (16'h0003)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .mem_header_i      (mem_header_i),
        .mem_data_i        (mem_data_i),
        .mem_v_i           (mem_v_i),
        .mem_last_i        (mem_last_i),
        .mem_ready_and_o   (mem_ready_and_o),
        .fsm_base_header_o (fsm_base_header_o),
        .fsm_addr_o        (fsm_addr_o),
        .fsm_data_o        (fsm_data_o),
        .fsm_v_o           (fsm_v_o),
        .fsm_ready_and_i   (fsm_ready_and_i),
        .stream_cnt_o      (stream_cnt_o),
        .stream_new_o      (stream_new_o),
        .stream_done_o     (stream_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [39:0] addr;
        logic [2:0]  cnt;
        logic        nw;
        logic        dn;
        logic        mrdy;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [39:0] t1_addr [8] = '{40'h1018, 40'h1020, 40'h1028, 40'h1030,
                                 40'h1038, 40'h1000, 40'h1008, 40'h1010};
    logic [2:0]  t1_cnt  [8] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [C_HDR_W-1:0] hdr(input logic [3:0] t, input logic [2:0] sz,
                                               input logic [39:0] a);
        return {8'h00, a, sz, t};
    endfunction

    function automatic void push(input logic [39:0] a, input logic [2:0] c, input logic nw,
                                 input logic dn, input logic mr, input logic [63:0] d);
        exp_q.push_back('{a, c, nw, dn, mr, d});
    endfunction

    // Monitor: every accepted FSM beat is matched against the scoreboard
    always @(negedge clk_i) begin
        if (!reset_i && fsm_v_o && fsm_ready_and_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got addr 0x%0h, expected no beat", fsm_addr_o);
            end else begin
                e = exp_q.pop_front();
                chk("beat_addr", 64'(fsm_addr_o), 64'(e.addr));
                chk("beat_cnt",  64'(stream_cnt_o), 64'(e.cnt));
                chk("beat_new",  64'(stream_new_o), 64'(e.nw));
                chk("beat_done", 64'(stream_done_o), 64'(e.dn));
                chk("beat_mrdy", 64'(mem_ready_and_o), 64'(e.mrdy));
                chk("beat_data", fsm_data_o, e.data);
            end
        end
    end

    // Present one bus beat and hold it until the pump acknowledges it
    task automatic beat(input logic [C_HDR_W-1:0] h, input logic [63:0] d, input logic last,
                        input string name);
        bit got = 1'b0;
        mem_header_i = h;
        mem_data_i   = d;
        mem_last_i   = last;
        mem_v_i      = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i);
            if (mem_ready_and_o) got = 1'b1;
            @(posedge clk_i);
            #1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no mem_ready_and_o, expected handshake", name);
        end
        mem_v_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Outputs must stay quiet under reset even with a valid header offered
        mem_header_i = hdr(4'd0, 3'd6, 40'h1018);
        mem_v_i      = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_fsm_v", 64'(fsm_v_o), 64'd0);
        chk("rst_mrdy",  64'(mem_ready_and_o), 64'd0);
        chk("rst_new",   64'(stream_new_o), 64'd0);
        chk("rst_done",  64'(stream_done_o), 64'd0);
        mem_v_i      = 1'b0;
        mem_header_i = '0;
        reset_i      = 1'b0;
        @(posedge clk_i);
        #1;
        chk("idle_fsm_v", 64'(fsm_v_o), 64'd0);
        chk("idle_cnt",   64'(stream_cnt_o), 64'd0);

        // Expanded 64B read with wrap
        for (int i = 0; i < 8; i++) push(t1_addr[i], t1_cnt[i], i == 0, i == 7, i == 7, 64'hA5A5);
        beat(hdr(4'd0, 3'd6, 40'h1018), 64'hA5A5, 1'b1, "t1");

        // 64B write with payload, one FSM beat per bus beat
        for (int i = 0; i < 8; i++)
            push(40'h2000 + 40'(8 * i), 3'(i), i == 0, i == 7, 1'b1, 64'hD000 + 64'(i));
        for (int i = 0; i < 8; i++)
            beat(hdr(4'd1, 3'd6, 40'h2000), 64'hD000 + 64'(i), i == 7, "t2");

        // Back to back: 8B read, 16B read, non-streamed uncached 64B read
        push(40'h3010, 3'd2, 1'b1, 1'b1, 1'b1, 64'h33);
        push(40'h4008, 3'd1, 1'b1, 1'b0, 1'b0, 64'h44);
        push(40'h4000, 3'd0, 1'b0, 1'b1, 1'b1, 64'h44);
        push(40'h8028, 3'd5, 1'b1, 1'b1, 1'b1, 64'h88);
        beat(hdr(4'd0, 3'd3, 40'h3010), 64'h33, 1'b1, "t3");
        beat(hdr(4'd0, 3'd4, 40'h4008), 64'h44, 1'b1, "t4");
        beat(hdr(4'd2, 3'd6, 40'h8028), 64'h88, 1'b1, "t_uc");

        // Back-pressure for 3 cycles after two beats
        for (int i = 0; i < 8; i++) push(40'h6000 + 40'(8 * i), 3'(i), i == 0, i == 7, i == 7, 64'h66);
        mem_header_i = hdr(4'd0, 3'd6, 40'h6000);
        mem_data_i   = 64'h66;
        mem_last_i   = 1'b1;
        mem_v_i      = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        fsm_ready_and_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            chk("stall_cnt",  64'(stream_cnt_o), 64'd2);
            chk("stall_addr", 64'(fsm_addr_o), 64'h6010);
            chk("stall_mrdy", 64'(mem_ready_and_o), 64'd0);
            @(posedge clk_i);
            #1;
        end
        fsm_ready_and_i = 1'b1;
        beat(hdr(4'd0, 3'd6, 40'h6000), 64'h66, 1'b1, "t5");

        // Reset after three beats of a 64B read
        push(40'h7018, 3'd3, 1'b1, 1'b0, 1'b0, 64'h77);
        push(40'h7020, 3'd4, 1'b0, 1'b0, 1'b0, 64'h77);
        push(40'h7028, 3'd5, 1'b0, 1'b0, 1'b0, 64'h77);
        mem_header_i = hdr(4'd0, 3'd6, 40'h7018);
        mem_data_i   = 64'h77;
        mem_last_i   = 1'b1;
        mem_v_i      = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rst2_fsm_v", 64'(fsm_v_o), 64'd0);
        chk("rst2_mrdy",  64'(mem_ready_and_o), 64'd0);
        chk("rst2_new",   64'(stream_new_o), 64'd0);
        chk("rst2_done",  64'(stream_done_o), 64'd0);
        mem_v_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        for (int i = 0; i < 8; i++) push(40'h5000 + 40'(8 * i), 3'(i), i == 0, i == 7, i == 7, 64'h55);
        beat(hdr(4'd0, 3'd6, 40'h5000), 64'h55, 1'b1, "t6");

        repeat (3) @(negedge clk_i);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
